// File: rtl/inst_queue.sv
// inst_queue: two-in / two-out circular instruction buffer between IF and ID.
// Holds PC, instruction, exception and prediction metadata per entry and
// empties itself on exception or branch flush.
module inst_queue #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 20,
  parameter int PRED_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              excep_flush_i,
  input  logic              branch_flush_i,
  input  logic              in_valid1_i,
  input  logic              in_valid2_i,
  input  logic [PC_W-1:0]   in_pc1_i,
  input  logic [PC_W-1:0]   in_pc2_i,
  input  logic [INST_W-1:0] in_inst1_i,
  input  logic [INST_W-1:0] in_inst2_i,
  input  logic              in_exc_en1_i,
  input  logic              in_exc_en2_i,
  input  logic [EXC_W-1:0]  in_exc_type1_i,
  input  logic [EXC_W-1:0]  in_exc_type2_i,
  input  logic [PRED_W-1:0] in_pred1_i,
  input  logic [PRED_W-1:0] in_pred2_i,
  output logic              allowin_o,
  output logic              out_valid1_o,
  output logic              out_valid2_o,
  output logic [PC_W-1:0]   out_pc1_o,
  output logic [PC_W-1:0]   out_pc2_o,
  output logic [INST_W-1:0] out_inst1_o,
  output logic [INST_W-1:0] out_inst2_o,
  output logic              out_exc_en1_o,
  output logic              out_exc_en2_o,
  output logic [EXC_W-1:0]  out_exc_type1_o,
  output logic [EXC_W-1:0]  out_exc_type2_o,
  output logic [PRED_W-1:0] out_pred1_o,
  output logic [PRED_W-1:0] out_pred2_o,
  input  logic              pop1_i,
  input  logic              pop2_i
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam int EntW = PC_W + INST_W + 1 + EXC_W + PRED_W;

  // Each entry is packed as {pc, inst, exc_en, exc_type, pred}
  logic [EntW-1:0] entryMem [DEPTH];

  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [PtrW-1:0] rdPtrPlus1;
  logic [PtrW-1:0] wrPtrPlus1;
  logic            flush;
  logic            push1, push2;
  logic            pop1, pop2;
  logic [1:0]      pushN, popN;

  assign flush      = excep_flush_i | branch_flush_i;
  assign rdPtrPlus1 = rdPtr_q + PtrW'(1);
  assign wrPtrPlus1 = wrPtr_q + PtrW'(1);

  // Two free slots are always required, so a two-line push can never overflow
  assign allowin_o = (count_q <= CntW'(DEPTH - 2));

  assign push1 = in_valid1_i & allowin_o & ~flush;
  assign push2 = push1 & in_valid2_i;
  assign pushN = {1'b0, push1} + {1'b0, push2};

  // Presentation reads straight from storage; an excepting head issues alone
  assign {out_pc1_o, out_inst1_o, out_exc_en1_o, out_exc_type1_o, out_pred1_o} = entryMem[rdPtr_q];
  assign {out_pc2_o, out_inst2_o, out_exc_en2_o, out_exc_type2_o, out_pred2_o} = entryMem[rdPtrPlus1];

  assign out_valid1_o = (count_q != '0);
  assign out_valid2_o = (count_q >= CntW'(2)) & ~out_exc_en1_o;

  assign pop1 = pop1_i & out_valid1_o;
  assign pop2 = pop1_i & pop2_i & out_valid2_o;
  assign popN = {1'b0, pop1} + {1'b0, pop2};

  // Next-state pointers and occupancy; a flush discards same-cycle pushes and pops
  always_comb begin
    rdPtr_d = rdPtr_q + PtrW'(popN);
    wrPtr_d = wrPtr_q + PtrW'(pushN);
    count_d = count_q + CntW'(pushN) - CntW'(popN);
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage: line1 at wrPtr, line2 at wrPtr+1; contents are never reset
  always_ff @(posedge clk) begin
    if (push1) begin
      entryMem[wrPtr_q] <= {in_pc1_i, in_inst1_i, in_exc_en1_i, in_exc_type1_i, in_pred1_i};
    end
    if (push2) begin
      entryMem[wrPtrPlus1] <= {in_pc2_i, in_inst2_i, in_exc_en2_i, in_exc_type2_i, in_pred2_i};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed table-driven bench for inst_queue (DEPTH=8), plus
// hand-written sequences for full-queue popping across wrap and async reset.
module tb_inst_queue;

  logic        clk;
  logic        rst;
  logic        excep_flush_i, branch_flush_i;
  logic        in_valid1_i, in_valid2_i;
  logic [31:0] in_pc1_i, in_pc2_i, in_inst1_i, in_inst2_i;
  logic        in_exc_en1_i, in_exc_en2_i;
  logic [19:0] in_exc_type1_i, in_exc_type2_i;
  logic [35:0] in_pred1_i, in_pred2_i;
  logic        allowin_o, out_valid1_o, out_valid2_o;
  logic [31:0] out_pc1_o, out_pc2_o, out_inst1_o, out_inst2_o;
  logic        out_exc_en1_o, out_exc_en2_o;
  logic [19:0] out_exc_type1_o, out_exc_type2_o;
  logic [35:0] out_pred1_o, out_pred2_o;
  logic        pop1_i, pop2_i;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct packed {
    logic        bFlush;
    logic        eFlush;
    logic        v1;
    logic        v2;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic        exc1;
    logic        p1;
    logic        p2;
    logic        expAllow;
    logic        expV1;
    logic        expV2;
    logic [31:0] expPc1;
    logic [31:0] expPc2;
  } vec_t;

  vec_t vecs[$];

  inst_queue #(.DEPTH(8), .PC_W(32), .INST_W(32), .EXC_W(20), .PRED_W(36)) dut (
    .clk(clk), .rst(rst),
    .excep_flush_i(excep_flush_i), .branch_flush_i(branch_flush_i),
    .in_valid1_i(in_valid1_i), .in_valid2_i(in_valid2_i),
    .in_pc1_i(in_pc1_i), .in_pc2_i(in_pc2_i),
    .in_inst1_i(in_inst1_i), .in_inst2_i(in_inst2_i),
    .in_exc_en1_i(in_exc_en1_i), .in_exc_en2_i(in_exc_en2_i),
    .in_exc_type1_i(in_exc_type1_i), .in_exc_type2_i(in_exc_type2_i),
    .in_pred1_i(in_pred1_i), .in_pred2_i(in_pred2_i),
    .allowin_o(allowin_o),
    .out_valid1_o(out_valid1_o), .out_valid2_o(out_valid2_o),
    .out_pc1_o(out_pc1_o), .out_pc2_o(out_pc2_o),
    .out_inst1_o(out_inst1_o), .out_inst2_o(out_inst2_o),
    .out_exc_en1_o(out_exc_en1_o), .out_exc_en2_o(out_exc_en2_o),
    .out_exc_type1_o(out_exc_type1_o), .out_exc_type2_o(out_exc_type2_o),
    .out_pred1_o(out_pred1_o), .out_pred2_o(out_pred2_o),
    .pop1_i(pop1_i), .pop2_i(pop2_i)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word and prediction payload are derived from the PC so that
  // their expected values follow from the expected PC
  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return pc ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [35:0] predOf(input logic [31:0] pc);
    return {4'hA, pc};
  endfunction

  function automatic vec_t mkVec(input logic bFl, input logic eFl, input logic v1, input logic v2,
                                 input logic [31:0] pc1, input logic [31:0] pc2, input logic exc1,
                                 input logic p1, input logic p2, input logic eAllow, input logic eV1,
                                 input logic eV2, input logic [31:0] ePc1, input logic [31:0] ePc2);
    vec_t v;
    v.bFlush = bFl;  v.eFlush = eFl;  v.v1 = v1;  v.v2 = v2;
    v.pc1 = pc1;     v.pc2 = pc2;     v.exc1 = exc1;
    v.p1 = p1;       v.p2 = p2;
    v.expAllow = eAllow; v.expV1 = eV1; v.expV2 = eV2;
    v.expPc1 = ePc1; v.expPc2 = ePc2;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then step past the rising edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    branch_flush_i = v.bFlush;
    excep_flush_i  = v.eFlush;
    in_valid1_i    = v.v1;
    in_valid2_i    = v.v2;
    in_pc1_i       = v.pc1;
    in_pc2_i       = v.pc2;
    in_inst1_i     = instOf(v.pc1);
    in_inst2_i     = instOf(v.pc2);
    in_exc_en1_i   = v.exc1;
    in_exc_en2_i   = 1'b0;
    in_exc_type1_i = v.exc1 ? 20'h00040 : 20'h00000;
    in_exc_type2_i = 20'h00000;
    in_pred1_i     = predOf(v.pc1);
    in_pred2_i     = predOf(v.pc2);
    pop1_i         = v.p1;
    pop2_i         = v.p2;
    @(posedge clk);
    #1;
  endtask

  // Compare presented outputs against the expected half of a vector
  task automatic checkOutput(input string name, input vec_t v);
    vecCount++;
    if (allowin_o !== v.expAllow) begin
      missCount++;
      $display("[TB] FAIL %s allowin: got %b expected %b", name, allowin_o, v.expAllow);
    end
    if (out_valid1_o !== v.expV1) begin
      missCount++;
      $display("[TB] FAIL %s out_valid1: got %b expected %b", name, out_valid1_o, v.expV1);
    end
    if (out_valid2_o !== v.expV2) begin
      missCount++;
      $display("[TB] FAIL %s out_valid2: got %b expected %b", name, out_valid2_o, v.expV2);
    end
    if (v.expV1) begin
      if (out_pc1_o !== v.expPc1) begin
        missCount++;
        $display("[TB] FAIL %s out_pc1: got %h expected %h", name, out_pc1_o, v.expPc1);
      end
      if (out_inst1_o !== instOf(v.expPc1)) begin
        missCount++;
        $display("[TB] FAIL %s out_inst1: got %h expected %h", name, out_inst1_o, instOf(v.expPc1));
      end
      if (out_pred1_o !== predOf(v.expPc1)) begin
        missCount++;
        $display("[TB] FAIL %s out_pred1: got %h expected %h", name, out_pred1_o, predOf(v.expPc1));
      end
    end
    if (v.expV2) begin
      if (out_pc2_o !== v.expPc2) begin
        missCount++;
        $display("[TB] FAIL %s out_pc2: got %h expected %h", name, out_pc2_o, v.expPc2);
      end
      if (out_inst2_o !== instOf(v.expPc2)) begin
        missCount++;
        $display("[TB] FAIL %s out_inst2: got %h expected %h", name, out_inst2_o, instOf(v.expPc2));
      end
    end
  endtask

  localparam logic [31:0] A  = 32'h1c00_0000;
  localparam logic [31:0] B  = 32'h2000_0000;
  localparam logic [31:0] C  = 32'h3000_0000;
  localparam logic [31:0] D  = 32'h4000_0000;
  localparam logic [31:0] F  = 32'h5000_0000;
  localparam logic [31:0] E  = 32'h6000_0000;
  localparam logic [31:0] BD = 32'hBAD0_0000;

  // Main sequence: table vectors, then wrap/full and async-reset sequences
  initial begin
    vec_t v;
    vec_t idle;

    rst = 1'b1;
    excep_flush_i = 1'b0; branch_flush_i = 1'b0;
    in_valid1_i = 1'b0; in_valid2_i = 1'b0;
    in_pc1_i = '0; in_pc2_i = '0; in_inst1_i = '0; in_inst2_i = '0;
    in_exc_en1_i = 1'b0; in_exc_en2_i = 1'b0;
    in_exc_type1_i = '0; in_exc_type2_i = '0;
    in_pred1_i = '0; in_pred2_i = '0;
    pop1_i = 1'b0; pop2_i = 1'b0;

    idle = mkVec(0,0,0,0, 32'h0, 32'h0, 0, 0,0, 1,0,0, 32'h0, 32'h0);

    //              bFl eFl v1 v2 pc1        pc2        exc p1 p2  allow v1 v2 expPc1     expPc2
    vecs.push_back(mkVec(0,0, 1,1, A,         A+32'h04,  0, 0,0,  1,1,1, A,         A+32'h04));
    vecs.push_back(mkVec(0,0, 1,1, A+32'h08,  A+32'h0C,  0, 0,0,  1,1,1, A,         A+32'h04));
    vecs.push_back(mkVec(0,0, 1,1, A+32'h10,  A+32'h14,  0, 0,0,  1,1,1, A,         A+32'h04));
    vecs.push_back(mkVec(0,0, 1,0, A+32'h18,  32'h0,     0, 0,0,  0,1,1, A,         A+32'h04));
    vecs.push_back(mkVec(0,0, 1,1, 32'hDEAD0000, 32'hDEAD0004, 0, 0,0, 0,1,1, A,     A+32'h04));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,1,  1,1,1, A+32'h08,  A+32'h0C));
    vecs.push_back(mkVec(0,0, 1,1, A+32'h1C,  A+32'h20,  0, 0,0,  0,1,1, A+32'h08,  A+32'h0C));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,0,  1,1,1, A+32'h0C,  A+32'h10));
    vecs.push_back(mkVec(0,0, 1,1, A+32'h24,  A+32'h28,  0, 1,1,  1,1,1, A+32'h14,  A+32'h18));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,1,  1,1,1, A+32'h1C,  A+32'h20));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,1,  1,1,1, A+32'h24,  A+32'h28));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,0,  1,1,0, A+32'h28,  32'h0));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,0,  1,0,0, 32'h0,     32'h0));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,1,  1,0,0, 32'h0,     32'h0));
    vecs.push_back(mkVec(0,0, 1,1, B,         B+32'h04,  1, 0,0,  1,1,0, B,         32'h0));
    vecs.push_back(mkVec(0,0, 0,0, 32'h0,     32'h0,     0, 1,1,  1,1,0, B+32'h04,  32'h0));
    vecs.push_back(mkVec(0,0, 1,1, B+32'h08,  B+32'h0C,  0, 0,0,  1,1,1, B+32'h04,  B+32'h08));
    vecs.push_back(mkVec(0,0, 1,1, B+32'h10,  B+32'h14,  0, 0,0,  1,1,1, B+32'h04,  B+32'h08));
    vecs.push_back(mkVec(1,0, 1,1, BD,        BD+32'h04, 0, 1,1,  1,0,0, 32'h0,     32'h0));
    vecs.push_back(mkVec(0,0, 1,1, C,         C+32'h04,  0, 0,0,  1,1,1, C,         C+32'h04));
    vecs.push_back(mkVec(0,1, 0,0, 32'h0,     32'h0,     0, 0,0,  1,0,0, 32'h0,     32'h0));
    vecs.push_back(mkVec(0,0, 0,1, BD,        BD+32'h04, 0, 0,0,  1,0,0, 32'h0,     32'h0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset", idle);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Move both pointers to 4 with an empty queue
    applyStimulus(mkVec(0,0, 1,1, D, D+32'h04, 0, 0,0, 1,1,1, D, D+32'h04));
    checkOutput("align0", mkVec(0,0, 1,1, D, D+32'h04, 0, 0,0, 1,1,1, D, D+32'h04));
    applyStimulus(mkVec(0,0, 1,1, D+32'h08, D+32'h0C, 0, 1,1, 1,1,1, D+32'h08, D+32'h0C));
    checkOutput("align1", mkVec(0,0, 1,1, D+32'h08, D+32'h0C, 0, 1,1, 1,1,1, D+32'h08, D+32'h0C));
    applyStimulus(mkVec(0,0, 0,0, 32'h0, 32'h0, 0, 1,1, 1,0,0, 32'h0, 32'h0));
    checkOutput("align2", mkVec(0,0, 0,0, 32'h0, 32'h0, 0, 1,1, 1,0,0, 32'h0, 32'h0));

    // Fill to 8 entries (slots 4..7 then 0..3), head stays F0/F1
    for (int k = 0; k < 4; k++) begin
      v = mkVec(0,0, 1,1, F + 32'(8*k), F + 32'(8*k + 4), 0, 0,0, (k < 3), 1,1, F, F+32'h04);
      applyStimulus(v);
      checkOutput($sformatf("fill%0d", k), v);
    end

    // pop2 / pop1 / pop2 from full: head crosses slot 7 -> 0
    v = mkVec(0,0, 0,0, 32'h0, 32'h0, 0, 1,1, 1,1,1, F+32'h08, F+32'h0C);
    applyStimulus(v);
    checkOutput("fullPop2", v);
    v = mkVec(0,0, 0,0, 32'h0, 32'h0, 0, 1,0, 1,1,1, F+32'h0C, F+32'h10);
    applyStimulus(v);
    checkOutput("fullPop1", v);
    v = mkVec(0,0, 0,0, 32'h0, 32'h0, 0, 1,1, 1,1,1, F+32'h14, F+32'h18);
    applyStimulus(v);
    checkOutput("fullPop2b", v);

    // Bring count to 4 then reset asynchronously between clock edges
    v = mkVec(0,0, 1,0, E+32'h40, 32'h0, 0, 0,0, 1,1,1, F+32'h14, F+32'h18);
    applyStimulus(v);
    checkOutput("preReset", v);
    applyStimulus(idle);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", idle);
    @(negedge clk);
    rst = 1'b0;
    v = mkVec(0,0, 1,1, E, E+32'h04, 0, 0,0, 1,1,1, E, E+32'h04);
    applyStimulus(v);
    checkOutput("postReset", v);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Decoupling instruction buffer between the IF stage and the ID stage. It accepts up to two fetched instructions per cycle (line1/line2) from IF and holds them, with PC, exception and branch-prediction metadata, in a circular FIFO. It presents up to two oldest entries to ID, which pops zero, one or two per cycle. Exception and branch flushes empty the queue so that no wrong-path instruction reaches decode.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, >= 4
- PC_W, 32, PC width
- INST_W, 32, instruction width
- EXC_W, 20, exception-type vector width (bit 0 = INT … bit 19 = IF_PPI)
- PRED_W, 36, prediction payload {branch, pht_state[1:0], btb_hit, btb_pc[31:0]}

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- excep_flush_i  in  1  exception/ertn flush from commit
- branch_flush_i  in  1  branch-mispredict flush from EXE
- in_valid1_i  in  1  line1 valid from IF
- in_valid2_i  in  1  line2 valid from IF; meaningful only with in_valid1_i
- in_pc1_i / in_pc2_i  in  PC_W  line PCs
- in_inst1_i / in_inst2_i  in  INST_W  instruction words
- in_exc_en1_i / in_exc_en2_i  in  1  line carries exception
- in_exc_type1_i / in_exc_type2_i  in  EXC_W  exception vectors
- in_pred1_i / in_pred2_i  in  PRED_W  prediction payload
- allowin_o  out  1  queue can accept a two-line push this cycle
- out_valid1_o / out_valid2_o  out  1  head / head+1 entry presented
- out_pc1_o / out_pc2_o, out_inst1_o / out_inst2_o, out_exc_en1_o / out_exc_en2_o, out_exc_type1_o / out_exc_type2_o, out_pred1_o / out_pred2_o  out  per field  entry contents
- pop1_i  in  1  ID consumes head entry
- pop2_i  in  1  ID also consumes head+1; legal only with pop1_i

## Operation
- Storage: DEPTH-entry array, rd_ptr and wr_ptr of log2(DEPTH) bits that wrap modulo DEPTH, and count of log2(DEPTH)+1 bits.
- allowin_o = (count <= DEPTH-2). It depends only on registered count, with no same-cycle pop credit.
- Push: push1 = in_valid1_i & allowin_o & ~flush; push2 = push1 & in_valid2_i.
  - Line1 is written at wr_ptr, line2 at wr_ptr+1.
  - wr_ptr advances by push1+push2.
  - in_valid2_i without in_valid1_i is ignored.
- Presentation is combinational from the array:
  - out_valid1_o = (count >= 1).
  - out_valid2_o = (count >= 2) & ~head.exc_en. An excepting head instruction is always issued alone.
  - out_*1 = entry[rd_ptr], out_*2 = entry[rd_ptr+1]. Data fields are don't-care when the corresponding valid is 0.
- Pop: pop_n = (pop1_i & out_valid1_o) + (pop1_i & pop2_i & out_valid2_o).
  - Pops without the matching valid are masked.
  - pop2_i without pop1_i is ignored.
  - rd_ptr advances by pop_n.
- Count update: count_next = count + push_n − pop_n. Simultaneous push and pop in one cycle are both honoured.
- Flush (excep_flush_i | branch_flush_i):
  - Next cycle: count=0, rd_ptr=wr_ptr=0.
  - Same-cycle pushes and pops are discarded.
  - Both flushes have identical effect.
- Overflow cannot occur, because allowin_o guarantees two free slots. Underflow cannot occur because of pop masking.
- Reset: count=0, rd_ptr=wr_ptr=0, so out_valid1_o=out_valid2_o=0 and allowin_o=1. Array contents are not reset.
- Reset asserted mid-operation clears the queue asynchronously. It has the same observable result as a flush, but takes effect immediately rather than at the next edge.

## Timing
- Push-to-present latency is 1 cycle: entries pushed at edge N are visible on out_* after edge N. There is no same-cycle bypass.
- allowin_o, out_valid*_o and out_* are combinational from registers only. None depends on in_* or pop*_i inputs, so there are no combinational loops with IF or ID.
- A pop at edge N exposes the next entries after edge N.
- Flush is sampled at edge N. From edge N the queue is empty and allowin_o=1. A push at N+1 is accepted normally.
- Wrap-around is seamless:
  - wr_ptr=DEPTH-1 with a two-line push writes entries DEPTH-1 and 0.
  - rd_ptr=DEPTH-1 presents entries DEPTH-1 and 0.
- Throughput: sustained 2 in / 2 out per cycle with no bubbles when count stays <= DEPTH-2.

## Test plan
- Reset, then push {pc1=0x1c000000, pc2=0x1c000004} with no pops → next cycle count=2, out_valid1=out_valid2=1, out_pc1=0x1c000000, out_pc2=0x1c000004.
- Push 2 per cycle without popping (DEPTH=8) → allowin_o drops to 0 when count=7 or 8. A push offered while allowin_o=0 is not stored; contents stay unchanged.
- count=8; pop2, then pop1, then pop2 → count goes 6, 5, 3, and order is preserved across wrap (rd_ptr 7→0) with line1 entries before line2 entries.
- Head entry with exc_en=1 (ADEF bit 6 set) followed by a normal entry → out_valid2=0. pop1 removes the head, and the next cycle shows the normal entry with out_valid1=1.
- count=5, simultaneous branch_flush_i, two-line push and pop2 → next cycle count=0, out_valid1=0, allowin_o=1. The pushed PCs never appear at the output.
- Assert rst asynchronously mid-stream with count=4 → out_valid1/2 go to 0 before the next clock edge. After release, the first push appears one cycle later.
